clock_sel_ctrl: RTL and testbench
=================================

// Module: clock_sel_ctrl
// PURPOSE
//   Sequencer that drives the 2-bit select of the 4-input clock mux safely.
//   Accepts a frequency-change request over a valid/ready handshake, then runs fixed steps:
//   gate the downstream clock off, wait, change sel, wait, re-enable the gate.
//   Runs on the free-running system clock, not on any muxed clock.
//   Provides sel, clk_gate_en and completion status to the ALU clocking logic.
// PARAMETERS
//   SEL_W          2    width of mux select / request code
//   SETTLE_CYCLES  16   cycles held in each wait phase (must be >= 1)
//   CNT_W          8    settle counter width (2**CNT_W > SETTLE_CYCLES)
//   RESET_SEL      0    sel value driven out of reset (selects clk0)
// PORTS
//   clk          in   1      system clock; all logic on rising edge
//   rst          in   1      asynchronous reset, active-high
//   req_valid    in   1      request to switch to req_sel
//   req_sel      in   SEL_W  requested mux select
//   req_ready    out  1      controller can accept a request (IDLE)
//   sel          out  SEL_W  registered select to the clock mux
//   clk_gate_en  out  1      1 = downstream muxed clock enabled
//   busy         out  1      switch sequence in progress
//   done         out  1      one-cycle pulse: sequence complete / no-op request retired
// BEHAVIOUR
//   Reset (async, immediate): sel=RESET_SEL, clk_gate_en=1, req_ready=1, busy=0, done=0,
//     counter=0, FSM=IDLE. Asserting rst mid-sequence aborts it. Outputs go to these
//     values at once; nothing is remembered of the aborted request.
//   All outputs are registered.
//   FSM states: IDLE, GATE_OFF, SWITCH_WAIT, DONE.
//   IDLE: req_ready=1. A transfer happens at an edge where req_valid & req_ready.
//     - req_sel == sel: no-op. Stay in IDLE, no gating, done=1 for the next cycle only.
//     - req_sel != sel: latch req_sel, go to GATE_OFF. clk_gate_en=0, busy=1, req_ready=0,
//       counter=SETTLE_CYCLES-1.
//   GATE_OFF: decrement each cycle. At count 0: sel<=latched value,
//     counter=SETTLE_CYCLES-1, go to SWITCH_WAIT. sel changes only while the gate is off.
//   SWITCH_WAIT: decrement each cycle. At count 0: clk_gate_en=1, done=1, go to DONE.
//   DONE: one cycle. busy=0, req_ready=1, done returns to 0, go to IDLE.
//   Timing (E0 = accept edge): gate low after E0; sel changes at E0+SETTLE_CYCLES;
//     gate high and done=1 at E0+2*SETTLE_CYCLES; req_ready=1 at E0+2*SETTLE_CYCLES+1.
//   Handshake: req_valid is ignored while req_ready=0; no queueing.
//     req_sel is sampled only at the accept edge.
//   The counter never wraps: it is loaded before each phase and stops at 0.
//   Illegal FSM encodings recover to IDLE with the reset output values.
// CONFIGURATION
//   SEL_LOCK_EN defined:
//     - Adds input sel_lock (1) and output reject (1).
//     - If sel_lock=1 at an IDLE accept edge, the request is consumed and sel is unchanged.
//       reject=1 for one cycle and done stays 0.
//     - sel_lock has no effect on a sequence already started.
//   SEL_LOCK_EN undefined:
//     - sel_lock and reject ports are absent.
//     - Every accepted request is executed as described above.
// TESTING (SETTLE_CYCLES=4, RESET_SEL=0)
//   Reset release: sel=0, clk_gate_en=1, req_ready=1, busy=0, done=0.
//   Request sel=2 accepted at E0:
//     - clk_gate_en=0 and busy=1 from E0.
//     - sel=2 at E0+4; clk_gate_en=1 and done=1 at E0+8.
//     - req_ready=1 at E0+9.
//   Request sel=0 while sel=0: no gate drop, done=1 for one cycle, busy stays 0.
//   req_valid held with sel=3 during a sel=1 sequence: ignored; final sel=1.
//     After req_ready returns, sel=3 is accepted and a new sequence starts.
//   rst pulse at E0+5 of a sequence: sel=0, clk_gate_en=1, req_ready=1 immediately.
//     No done pulse follows.
//   SEL_LOCK_EN: sel_lock=1, request sel=1 -> reject=1 for one cycle; sel=0, gate stays 1.
//     Lock raised at E0+2 of a running sequence -> sequence still completes with done.

Source files
------------

// File: rtl/clock_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_sel_ctrl
// Purpose  : Safe switching sequencer for the 2-bit select of a 4-input clock
//            mux. It accepts a frequency-change request over a valid/ready
//            handshake, then gates the downstream clock off, waits, changes
//            the select, waits again and re-enables the gate. It runs on the
//            free-running system clock, never on a muxed clock.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SEL_W          width of mux select / request code
//   SETTLE_CYCLES  cycles held in each wait phase (>= 1)
//   CNT_W          settle counter width (2**CNT_W > SETTLE_CYCLES)
//   RESET_SEL      select value driven out of reset
// Ports
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   sel_lock     in   1      (SEL_LOCK_EN only) refuse new requests
//   req_valid    in   1      request to switch to req_sel
//   req_sel      in   SEL_W  requested mux select
//   req_ready    out  1      controller idle, can accept a request
//   sel          out  SEL_W  registered select to the clock mux
//   clk_gate_en  out  1      1 = downstream muxed clock enabled
//   busy         out  1      switch sequence in progress
//   done         out  1      one-cycle pulse: sequence done / no-op retired
//   reject       out  1      (SEL_LOCK_EN only) one-cycle pulse: request
//                            consumed while locked
// Configuration
//   SEL_LOCK_EN    define to add the sel_lock input and reject output
// ============================================================================
module clock_sel_ctrl #(
  parameter int SEL_W         = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8,
  parameter int RESET_SEL     = 0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SEL_LOCK_EN
  input  logic             sel_lock,
  output logic             reject,
`endif
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_sel,
  output logic             req_ready,
  output logic [SEL_W-1:0] sel,
  output logic             clk_gate_en,
  output logic             busy,
  output logic             done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [SEL_W-1:0] SEL_RST  = SEL_W'(RESET_SEL);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_GATE_OFF    = 2'd1,
    ST_SWITCH_WAIT = 2'd2,
    ST_DONE        = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  state_t           state_q,       state_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic [SEL_W-1:0] target_q,      target_d;
  logic [SEL_W-1:0] sel_q,         sel_d;
  logic             gate_en_q,     gate_en_d;
  logic             req_ready_q,   req_ready_d;
  logic             busy_q,        busy_d;
  logic             done_q,        done_d;
`ifdef SEL_LOCK_EN
  logic             reject_q,      reject_d;
`endif

  // Handshake transfer: only meaningful while idle, since req_ready is low
  // for the whole sequence.
  logic accept;
  assign accept = req_valid & req_ready_q;

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    sel_d       = sel_q;
    gate_en_d   = gate_en_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef SEL_LOCK_EN
    reject_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        gate_en_d   = 1'b1;
        if (accept) begin
`ifdef SEL_LOCK_EN
          if (sel_lock) begin
            // Request is consumed but has no effect on the mux.
            reject_d = 1'b1;
          end else
`endif
          if (req_sel == sel_q) begin
            // Already on the requested clock: retire without gating.
            done_d = 1'b1;
          end else begin
            target_d    = req_sel;
            state_d     = ST_GATE_OFF;
            gate_en_d   = 1'b0;
            busy_d      = 1'b1;
            req_ready_d = 1'b0;
            cnt_d       = CNT_LOAD;
          end
        end
      end

      ST_GATE_OFF: begin
        // The select only moves here, with the downstream clock gated off.
        if (cnt_q == CNT_ZERO) begin
          sel_d   = target_q;
          cnt_d   = CNT_LOAD;
          state_d = ST_SWITCH_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_SWITCH_WAIT: begin
        if (cnt_q == CNT_ZERO) begin
          gate_en_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_DONE: begin
        busy_d      = 1'b0;
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        // Unreachable with a full 2-bit encoding; recover to reset values.
        state_d     = ST_IDLE;
        cnt_d       = CNT_ZERO;
        target_d    = SEL_RST;
        sel_d       = SEL_RST;
        gate_en_d   = 1'b1;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        done_d      = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers (asynchronous reset aborts any sequence immediately)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      target_q    <= SEL_RST;
      sel_q       <= SEL_RST;
      gate_en_q   <= 1'b1;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      sel_q       <= sel_d;
      gate_en_q   <= gate_en_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef SEL_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reject_q <= 1'b0;
    end else begin
      reject_q <= reject_d;
    end
  end

  assign reject = reject_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sel         = sel_q;
  assign clk_gate_en = gate_en_q;
  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_sel_ctrl
// Purpose  : Directed self-checking bench for clock_sel_ctrl with
//            SETTLE_CYCLES=4, RESET_SEL=0. Expected output vectors are queued
//            when stimulus is applied and compared after the clock edge.
//            Define SEL_LOCK_EN to exercise the lock/reject feature as well.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_sel_ctrl;

  localparam int SEL_W  = 2;
  localparam int SETTLE = 4;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             req_valid = 1'b0;
  logic [SEL_W-1:0] req_sel   = '0;
  logic             req_ready;
  logic [SEL_W-1:0] sel;
  logic             clk_gate_en;
  logic             busy;
  logic             done;
`ifdef SEL_LOCK_EN
  logic             sel_lock  = 1'b0;
  logic             reject;
`endif

  clock_sel_ctrl #(
    .SEL_W        (SEL_W),
    .SETTLE_CYCLES(SETTLE),
    .CNT_W        (8),
    .RESET_SEL    (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef SEL_LOCK_EN
    .sel_lock   (sel_lock),
    .reject     (reject),
`endif
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .sel        (sel),
    .clk_gate_en(clk_gate_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [1:0] sel;
    logic       gate;
    logic       ready;
    logic       busy;
    logic       done;
    logic       reject;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [1:0] cur_sel;

  task automatic cmp(input string tag, input string field,
                     input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [1:0] s, input logic g,
                      input logic r, input logic b, input logic d,
                      input logic rj);
    exp_t e;
    e.tag = tag; e.sel = s; e.gate = g; e.ready = r;
    e.busy = b; e.done = d; e.reject = rj;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "sel",         {6'd0, sel},         {6'd0, e.sel});
      cmp(e.tag, "clk_gate_en", {7'd0, clk_gate_en}, {7'd0, e.gate});
      cmp(e.tag, "req_ready",   {7'd0, req_ready},   {7'd0, e.ready});
      cmp(e.tag, "busy",        {7'd0, busy},        {7'd0, e.busy});
      cmp(e.tag, "done",        {7'd0, done},        {7'd0, e.done});
`ifdef SEL_LOCK_EN
      cmp(e.tag, "reject",      {7'd0, reject},      {7'd0, e.reject});
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_now();
  endtask

  // Drive a request that must be accepted at the next edge (E0).
  task automatic accept(input string tag, input logic [1:0] prev,
                        input logic [1:0] tgt);
    req_valid = 1'b1;
    req_sel   = tgt;
    push(tag, prev, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
  endtask

  // Check edges E0+from .. E0+upto against the documented timeline.
  task automatic run_seq(input string tag, input logic [1:0] prev,
                         input logic [1:0] tgt, input int from, input int upto);
    logic [1:0] s;
    for (int k = from; k <= upto; k++) begin
      s = (k >= SETTLE) ? tgt : prev;
      push($sformatf("%s_E%0d", tag, k), s,
           (k >= 2*SETTLE), (k >= 2*SETTLE+1), (k <= 2*SETTLE),
           (k == 2*SETTLE), 1'b0);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held, then released between edges.
    @(posedge clk); #1;
    push("reset_hold", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_now();
    rst = 1'b0;
    push("reset_rel", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    // No-op request: sel already 0.
    req_valid = 1'b1; req_sel = 2'd0;
    push("noop0", 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    req_valid = 1'b0;
    push("noop0_after", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    // Full sequence to sel=2.
    accept("seq2_E0", 2'd0, 2'd2);
    req_valid = 1'b0;
    req_sel   = 2'd1;  // must not matter after the accept edge
    run_seq("seq2", 2'd0, 2'd2, 1, 2*SETTLE+1);

    // sel=1 sequence with a sel=3 request held valid throughout.
    accept("seq1_E0", 2'd2, 2'd1);
    req_sel = 2'd3;
    run_seq("seq1", 2'd2, 2'd1, 1, 2*SETTLE+1);
    accept("seq3_E0", 2'd1, 2'd3);
    req_valid = 1'b0;
    run_seq("seq3", 2'd1, 2'd3, 1, 2*SETTLE+1);
    cur_sel = 2'd3;

`ifdef SEL_LOCK_EN
    // Locked request is consumed and rejected.
    sel_lock = 1'b1; req_valid = 1'b1; req_sel = 2'd1;
    push("lock_rej", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    req_valid = 1'b0;
    push("lock_rej_after", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    sel_lock = 1'b0;

    // Lock raised at E0+2 of a running sequence has no effect.
    accept("lockmid_E0", 2'd3, 2'd0);
    req_valid = 1'b0;
    run_seq("lockmid", 2'd3, 2'd0, 1, 2);
    sel_lock = 1'b1;
    run_seq("lockmid", 2'd3, 2'd0, 3, 2*SETTLE+1);
    sel_lock = 1'b0;
    cur_sel = 2'd0;
`endif

    // Asynchronous reset at E0+5 of a sequence.
    accept("rstmid_E0", cur_sel, 2'd2);
    req_valid = 1'b0;
    run_seq("rstmid", cur_sel, 2'd2, 1, 5);
    #1 rst = 1'b1;
    #1;
    push("rstmid_async", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_now();
    #2 rst = 1'b0;
    for (int i = 0; i < 2*SETTLE+2; i++) begin
      push($sformatf("rstmid_idle%0d", i), 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end

    // Nothing remembered: sel=0 request is a no-op after the abort.
    req_valid = 1'b1; req_sel = 2'd0;
    push("post_rst_noop", 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    req_valid = 1'b0;
    push("post_rst_noop_after", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
